bch_encode_serial: RTL
======================

// Module: bch_encode_serial
// PURPOSE
//   Bit-serial systematic binary BCH encoder; transmit-side counterpart of the serial decoder.
//   Accepts K message bits one per handshake, passes them through unchanged, then appends
//   E = deg g(x) parity bits: the remainder of m(x)*x^E mod g(x), taken from an LFSR.
//   Sits between the data source and the channel; its codewords feed the syndrome/decode chain.
// PARAMETERS
//   M     4           GF(2^M) field order; full code length N = 2^M-1
//   T     3           correctable errors; g(x) = LCM of minimal polys of a^1..a^(2T)
//   K     N-E         message bits per codeword (1..N-E); K < N-E gives a shortened code
//   localparam E      ECC bit count, deg g(x), from bch.vh helpers (M=4,T=3: E=10)
//   localparam GEN    g(x) coefficients [E:0], bit E = 1 (M=4,T=3: 11'b101_0011_0111)
// PORTS
//   clk         in   1  clock, all state on rising edge
//   reset       in   1  synchronous, active-high; clears all state
//   din         in   1  message bit, highest-order coefficient first
//   din_valid   in   1  din is valid
//   din_ready   out  1  encoder accepts din this cycle
//   dout        out  1  codeword bit, highest-order coefficient first
//   dout_valid  out  1  dout holds a valid bit
//   dout_ready  in   1  sink accepts dout this cycle
//   dout_first  out  1  dout is codeword bit 0 (first message bit)
//   dout_last   out  1  dout is the final parity bit
//   dout_ecc    out  1  dout is a parity bit (not a message bit)
// BEHAVIOUR
//   Reset: state=DATA, count=0, lfsr=0, dout=0, dout_valid=0, dout_first/last/ecc=0.
//   One output register. out_free = !dout_valid || dout_ready.
//   State DATA:
//     din_ready = out_free. Accept on din_valid && din_ready:
//     dout<=din, dout_valid<=1, dout_ecc<=0, dout_first<=(count==0), dout_last<=0.
//     Feedback fb = din ^ lfsr[E-1]; lfsr <= {lfsr[E-2:0],1'b0} ^ (fb ? GEN[E-1:0] : 0).
//     count++. On the K-th accept: count<=0, state<=PARITY.
//   State PARITY:
//     din_ready=0. Each cycle with out_free: dout<=lfsr[E-1], dout_valid<=1, dout_ecc<=1,
//     dout_first<=0, dout_last<=(count==E-1); lfsr <= {lfsr[E-2:0],1'b0}; count++.
//     After the E-th bit loads: count<=0, lfsr<=0 (already 0 by shifting), state<=DATA.
//     din_ready rises the cycle after; no bubble beyond that.
//   Output clear: when dout_valid && dout_ready && no new load, dout_valid<=0 and flags<=0.
//   Backpressure: while dout_valid && !dout_ready, dout and all flags hold stable, no
//     state/lfsr/count change, din_ready=0.
//   Latency: din to dout is 1 cycle; max throughput is 1 bit/cycle, N' = K+E cycles/codeword
//     plus 1 idle cycle of din_ready at the PARITY->DATA turn.
//   Count width: clog2(max(K,E)+1). din ignored when din_ready=0.
//   Reset mid-codeword: partial codeword is discarded, no parity emitted; next accepted bit
//     is treated as bit 0 (dout_first=1).
//   Pentanomial fields are legal here (LFSR uses only GEN).
// TESTING (M=4, T=3, K=5, E=10)
//   msg 00001 -> dout 00001_0100110111 (= g(x)); dout_first on bit 0, dout_ecc on bits 5..14,
//     dout_last on bit 14 only.
//   msg 00000 -> 15 zeros; msg 11111 -> 15 ones (all-ones word is a codeword).
//   Random msgs a,b: enc(a^b) == enc(a)^enc(b); every codeword divisible by g(x); feeding
//     into the decoder gives zero syndromes.
//   Full-rate back-to-back codewords with din_valid=dout_ready=1 -> 16 cycles per codeword,
//     din_ready low exactly during the 10 parity loads plus 1 turn cycle.
//   Random dout_ready stalls -> dout/flags stable while stalled, output stream matches golden.
//   reset asserted after 3 msg bits -> dout_valid=0 next cycle; following msg 00001 -> g(x).

Source files
------------

// File: rtl/bch_encode_serial.sv
// bch_encode_serial_pkg
//   Elaboration-time helpers for binary BCH codes over GF(2^m). They derive the
//   generator polynomial g(x) as the product of (x + a^r) over every root r in
//   the cyclotomic cosets of a^1..a^(2t). GF elements are carried in int
//   variables, so m is limited to 2..10 and deg g(x) to MAX_E.
//
// bch_encode_serial
//   Bit-serial systematic BCH encoder. Message bits enter one per handshake,
//   are forwarded unchanged, and are followed by E parity bits: the remainder
//   of m(x)*x^E mod g(x), shifted out of a division LFSR.
//   Ports:
//     clk         clock, rising edge
//     reset       synchronous active-high clear
//     din         message bit, highest-order coefficient first
//     din_valid   din is valid
//     din_ready   encoder accepts din this cycle
//     dout        codeword bit, highest-order coefficient first
//     dout_valid  dout holds a valid bit
//     dout_ready  sink accepts dout this cycle
//     dout_first  dout is codeword bit 0
//     dout_last   dout is the final parity bit
//     dout_ecc    dout is a parity bit

package bch_encode_serial_pkg;

  localparam int MAX_N = 1024;
  localparam int MAX_E = 64;

  // Primitive polynomial per field order; m = 8 is a pentanomial, which is
  // fine because the encoder datapath only ever uses g(x).
  function automatic int prim_poly(input int m);
    case (m)
      2:       return 'h7;
      3:       return 'hB;
      4:       return 'h13;
      5:       return 'h25;
      6:       return 'h43;
      7:       return 'h89;
      8:       return 'h11D;
      9:       return 'h211;
      10:      return 'h409;
      default: return 0;
    endcase
  endfunction

  function automatic int bch_n(input int m);
    return (1 << m) - 1;
  endfunction

  function automatic int gf_mul(input int a, input int b, input int m);
    int x;
    int r;
    int p;
    x = a;
    r = 0;
    p = prim_poly(m);
    for (int i = 0; i < m; i++) begin
      if (((b >> i) & 1) != 0) r = r ^ x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x = x ^ p;
    end
    return r;
  endfunction

  // Exponents r for which a^r is a root of g(x): closure of 1..2t under
  // doubling mod n.
  function automatic logic [MAX_N-1:0] root_set(input int m, input int t);
    logic [MAX_N-1:0] roots;
    int n;
    int j;
    n = bch_n(m);
    roots = '0;
    for (int i = 1; i <= 2 * t; i++) begin
      j = i % n;
      for (int c = 0; c < m; c++) begin
        roots[j] = 1'b1;
        j = (2 * j) % n;
      end
    end
    return roots;
  endfunction

  function automatic int bch_e(input int m, input int t);
    logic [MAX_N-1:0] roots;
    int e;
    roots = root_set(m, t);
    e = 0;
    for (int r = 0; r < bch_n(m); r++) begin
      if (roots[r]) e++;
    end
    return e;
  endfunction

  // g(x) = prod (x + a^r); coefficients are GF elements during the product
  // but collapse to 0/1 at the end, so only bit 0 of each is kept.
  function automatic logic [MAX_E:0] bch_gen(input int m, input int t);
    logic [MAX_N-1:0]       roots;
    logic [MAX_E:0][9:0]    c;
    logic [MAX_E:0]         g;
    int                     deg;
    int                     pw;
    roots = root_set(m, t);
    c = '0;
    c[0] = 10'd1;
    deg = 0;
    pw = 1;
    for (int r = 0; r < bch_n(m); r++) begin
      if (roots[r] && deg < MAX_E) begin
        for (int k = deg + 1; k >= 1; k--) begin
          c[k] = c[k-1] ^ 10'(gf_mul(int'(c[k]), pw, m));
        end
        c[0] = 10'(gf_mul(int'(c[0]), pw, m));
        deg++;
      end
      pw = gf_mul(pw, 2, m);
    end
    for (int k = 0; k <= MAX_E; k++) begin
      g[k] = c[k][0];
    end
    return g;
  endfunction

endpackage

// State table
//   state    | meaning
//   S_DATA   | accepting message bits, forwarding them and dividing into lfsr
//   S_PARITY | shifting lfsr out as parity; count==E is the one turn cycle
module bch_encode_serial
  import bch_encode_serial_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int K = bch_n(M) - bch_e(M, T)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  input  logic dout_ready,
  output logic dout_first,
  output logic dout_last,
  output logic dout_ecc
);

  localparam int              E        = bch_e(M, T);
  localparam logic [MAX_E:0]  GEN_FULL = bch_gen(M, T);
  localparam logic [E:0]      GEN      = GEN_FULL[E:0];
  localparam int              CW       = $clog2(((K > E) ? K : E) + 1);

  typedef enum logic {
    S_DATA,
    S_PARITY
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [E-1:0]  lfsr;
  logic          out_free;
  logic          accept;
  logic          par_load;
  logic          turn;
  logic          fb;
  logic          msg_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_DATA:   if (accept && msg_done) state_nxt = S_PARITY;
      S_PARITY: if (turn) state_nxt = S_DATA;
      default:  state_nxt = S_DATA;
    endcase
  end

  // Handshake and control decode
  always_comb begin
    out_free  = !dout_valid || dout_ready;
    din_ready = (state == S_DATA) && out_free;
    accept    = din_valid && din_ready;
    msg_done  = (count == CW'(K - 1));
    // After the last parity bit loads, count sits at E for one cycle so the
    // source sees din_ready low once more before the next codeword.
    par_load  = (state == S_PARITY) && out_free && (count != CW'(E));
    turn      = (state == S_PARITY) && out_free && (count == CW'(E));
    fb        = din ^ lfsr[E-1];
  end

  // Output register, division LFSR and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      lfsr       <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      dout_ecc   <= 1'b0;
    end else if (accept) begin
      dout       <= din;
      dout_valid <= 1'b1;
      dout_ecc   <= 1'b0;
      dout_first <= (count == '0);
      dout_last  <= 1'b0;
      lfsr       <= {lfsr[E-2:0], 1'b0} ^ (fb ? GEN[E-1:0] : '0);
      count      <= msg_done ? '0 : count + CW'(1);
    end else if (par_load) begin
      dout       <= lfsr[E-1];
      dout_valid <= 1'b1;
      dout_ecc   <= 1'b1;
      dout_first <= 1'b0;
      dout_last  <= (count == CW'(E - 1));
      lfsr       <= {lfsr[E-2:0], 1'b0};
      count      <= count + CW'(1);
    end else begin
      if (turn) begin
        count <= '0;
        lfsr  <= '0;
      end
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        dout_first <= 1'b0;
        dout_last  <= 1'b0;
        dout_ecc   <= 1'b0;
      end
    end
  end

endmodule
